// File: rtl/mixer_pkg.sv
// Shared types and helpers for the voice mixer and downstream audio stages.
// Holds the FSM state encoding, accumulator sizing and the saturating truncation.
package mixer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      ACCUM   = 2'd2,
      OUT     = 2'd3
   } mix_state_t;

   // One guard bit beyond the worst-case sum of num_voices full-scale samples.
   function automatic int acc_width(input int num_voices, input int width);
      return width + $clog2(num_voices) + 1;
   endfunction

   // Returns {clip, value}; the low 'width' bits of value hold the saturated result.
   function automatic logic [64:0] sat_trunc(input logic signed [63:0] value, input int width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v) begin
         return {1'b1, max_v};
      end else if (value < min_v) begin
         return {1'b1, min_v};
      end else begin
         return {1'b0, value};
      end
   endfunction

endpackage

// File: rtl/mixer_saturate.sv
// Arithmetic right shift followed by saturation to a narrower two's complement width.
// Purely combinational so it can sit in front of an output register in any stage.
module mixer_saturate
   import mixer_pkg::*;
#(
   parameter int IN_W    = 19,
   parameter int OUT_W   = 16,
   parameter int SHIFT_W = 3
) (
   input  logic signed [IN_W-1:0]    i_value,
   input  logic        [SHIFT_W-1:0] i_shift,
   output logic        [OUT_W-1:0]   o_value,
   output logic                      o_clip
);

   logic signed [IN_W-1:0] w_scaled;
   logic signed [63:0]     w_ext;
   logic        [64:0]     w_res;
   logic                   w_unused;

   // Shift, widen and saturate.
   always_comb begin
      w_scaled = i_value >>> i_shift;
      w_ext    = {{(64 - IN_W){w_scaled[IN_W-1]}}, w_scaled};
      w_res    = sat_trunc(w_ext, OUT_W);
   end

   assign o_value  = w_res[OUT_W-1:0];
   assign o_clip   = w_res[64];
   assign w_unused = ^w_res[63:OUT_W];

endmodule

// File: rtl/voice_mixer.sv
// N-voice sample mixer: captures each voice on its ready pulse, waits for all enabled
// voices (or a timeout), accumulates serially and emits one saturated sample per frame.
module voice_mixer
   import mixer_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int WIDTH      = 16,
   parameter int SHIFT_W    = 3,
   parameter int TIMEOUT    = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_VOICES*WIDTH-1:0]   voice_samples,
   input  logic [NUM_VOICES-1:0]         voice_ready,
   input  logic [NUM_VOICES-1:0]         voice_enable,
   input  logic [SHIFT_W-1:0]            shift,
   output logic [WIDTH-1:0]              sample_out,
   output logic                          new_sample_ready,
   output logic                          clip,
   output logic                          timeout
);

   localparam int ACC_W  = acc_width(NUM_VOICES, WIDTH);
   localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_VOICES - 1);
   localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [NUM_VOICES-1:0] NONE      = {NUM_VOICES{1'b0}};

   mix_state_t              r_state;
   logic signed [WIDTH-1:0] r_cap  [NUM_VOICES];
   logic signed [WIDTH-1:0] r_work [NUM_VOICES];
   logic [NUM_VOICES-1:0]   r_collected;
   logic [NUM_VOICES-1:0]   r_mask;
   logic                    r_timeout_flag;
   logic [WAIT_W-1:0]       r_wait_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic signed [ACC_W-1:0] r_acc;
   logic [WIDTH-1:0]        r_sample_out;
   logic                    r_new_sample_ready;
   logic                    r_clip;
   logic                    r_timeout;

   logic [NUM_VOICES-1:0]   w_capture;
   logic                    w_done;
   logic                    w_snapshot;
   logic signed [WIDTH-1:0] w_sel;
   logic signed [ACC_W-1:0] w_term;
   logic signed [ACC_W-1:0] w_acc_next;
   logic [WIDTH-1:0]        w_sat_value;
   logic                    w_sat_clip;

   // Frame completion, snapshot decision and the next accumulator value.
   always_comb begin
      w_capture  = voice_ready & voice_enable;
      w_done     = &(r_collected | ~voice_enable);
      w_snapshot = (r_state == COLLECT) && (w_done || (r_wait_cnt == WAIT_LAST));
      w_sel      = r_work[r_idx];
      if (r_mask[r_idx]) begin
         w_term = {{(ACC_W - WIDTH){w_sel[WIDTH-1]}}, w_sel};
      end else begin
         w_term = {ACC_W{1'b0}};
      end
      w_acc_next = r_acc + w_term;
   end

   // The final ACCUM sum feeds the saturator so the result registers on entry to OUT.
   mixer_saturate #(
      .IN_W    (ACC_W),
      .OUT_W   (WIDTH),
      .SHIFT_W (SHIFT_W)
   ) u_saturate (
      .i_value (w_acc_next),
      .i_shift (shift),
      .o_value (w_sat_value),
      .o_clip  (w_sat_clip)
   );

   // Capture registers, frame FSM, serial accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state            <= IDLE;
         r_collected        <= NONE;
         r_mask             <= NONE;
         r_timeout_flag     <= 1'b0;
         r_wait_cnt         <= {WAIT_W{1'b0}};
         r_idx              <= {IDX_W{1'b0}};
         r_acc              <= {ACC_W{1'b0}};
         r_sample_out       <= {WIDTH{1'b0}};
         r_new_sample_ready <= 1'b0;
         r_clip             <= 1'b0;
         r_timeout          <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_cap[i]  <= {WIDTH{1'b0}};
            r_work[i] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_capture[i]) begin
               r_cap[i] <= voice_samples[i*WIDTH +: WIDTH];
            end
         end
         // A ready landing in the snapshot cycle starts the next frame.
         r_collected        <= (w_snapshot ? NONE : r_collected) | w_capture;
         r_new_sample_ready <= 1'b0;
         r_clip             <= 1'b0;
         r_timeout          <= 1'b0;

         case (r_state)
            IDLE: begin
               if (r_collected != NONE) begin
                  r_state <= COLLECT;
               end
            end
            COLLECT: begin
               if (w_snapshot) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     r_work[i] <= r_cap[i];
                  end
                  r_mask         <= r_collected & voice_enable;
                  r_timeout_flag <= !w_done;
                  r_wait_cnt     <= {WAIT_W{1'b0}};
                  r_idx          <= {IDX_W{1'b0}};
                  r_acc          <= {ACC_W{1'b0}};
                  r_state        <= ACCUM;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            ACCUM: begin
               r_acc <= w_acc_next;
               if (r_idx == LAST_IDX) begin
                  r_sample_out       <= w_sat_value;
                  r_clip             <= w_sat_clip;
                  r_timeout          <= r_timeout_flag;
                  r_new_sample_ready <= 1'b1;
                  r_state            <= OUT;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            OUT: begin
               r_state <= (r_collected != NONE) ? COLLECT : IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign sample_out       = r_sample_out;
   assign new_sample_ready = r_new_sample_ready;
   assign clip             = r_clip;
   assign timeout          = r_timeout;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: table-driven frames plus hand-built multi-cycle
// sequences, with expected pulses queued at stimulus time and matched by a monitor.
module tb_voice_mixer;

   localparam int N  = 3;
   localparam int W  = 16;
   localparam int SW = 3;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*W-1:0]  voice_samples;
   logic [N-1:0]    voice_ready;
   logic [N-1:0]    voice_enable;
   logic [SW-1:0]   shift;
   logic [W-1:0]    sample_out;
   logic            new_sample_ready;
   logic            clip;
   logic            timeout;

   voice_mixer #(
      .NUM_VOICES (N),
      .WIDTH      (W),
      .SHIFT_W    (SW),
      .TIMEOUT    (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .voice_samples    (voice_samples),
      .voice_ready      (voice_ready),
      .voice_enable     (voice_enable),
      .shift            (shift),
      .sample_out       (sample_out),
      .new_sample_ready (new_sample_ready),
      .clip             (clip),
      .timeout          (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   typedef struct {
      int out;
      int clp;
      int to;
      int at;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [2:0] en;
      logic [2:0] rdy;
      int s0;
      int s1;
      int s2;
      int sh;
      int out;
      int clp;
   } vec_t;
   vec_t vt[12];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every output pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (new_sample_ready === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none, sample_out=%0d",
                     cyc, $signed(sample_out));
         end else begin
            e = sb.pop_front();
            check("sample_out", int'($signed(sample_out)), e.out);
            check("clip", int'(clip), e.clp);
            check("timeout", int'(timeout), e.to);
            check("pulse_cycle", cyc, e.at);
         end
      end
   end

   task automatic pulse(input logic [2:0] rdy, input int s0, input int s1, input int s2,
                        output int t);
      @(negedge clk);
      voice_samples = {W'(s2), W'(s1), W'(s0)};
      voice_ready   = rdy;
      t             = cyc;
      @(negedge clk);
      voice_ready   = 3'b000;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending pulses expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int t1;
      int t2;
      int p0;

      vt[0]  = '{3'b111, 3'b111,    100,    200,   -50, 0,    250, 0};
      vt[1]  = '{3'b111, 3'b111,  30000,  30000, 30000, 0,  32767, 1};
      vt[2]  = '{3'b111, 3'b111,  30000,  30000, 30000, 2,  22500, 0};
      vt[3]  = '{3'b111, 3'b111, -32768, -32768, -32768, 0, -32768, 1};
      vt[4]  = '{3'b011, 3'b111,      7,      8,  5000, 0,     15, 0};
      vt[5]  = '{3'b111, 3'b111,     -3,     -4,     0, 1,     -4, 0};
      vt[6]  = '{3'b111, 3'b111,  32767,  32767, 32767, 7,    767, 0};
      vt[7]  = '{3'b111, 3'b111,  32767,      0,     0, 0,  32767, 0};
      vt[8]  = '{3'b111, 3'b111,  32767,      1,     0, 0,  32767, 1};
      vt[9]  = '{3'b111, 3'b111, -32768,      0,     0, 0, -32768, 0};
      vt[10] = '{3'b111, 3'b111, -32768,     -1,     0, 0, -32768, 1};
      vt[11] = '{3'b111, 3'b111,     -1,     -1,    -1, 1,     -2, 0};

      reset         = 1'b1;
      voice_samples = '0;
      voice_ready   = 3'b000;
      voice_enable  = 3'b111;
      shift         = 3'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_sample_out", int'($signed(sample_out)), 0);
      check("reset_ready", int'(new_sample_ready), 0);
      check("reset_clip", int'(clip), 0);
      check("reset_timeout", int'(timeout), 0);

      // Same-cycle readies: IDLE, one COLLECT cycle, N ACCUM cycles, then the pulse.
      for (int i = 0; i < 12; i++) begin
         voice_enable = vt[i].en;
         shift        = SW'(vt[i].sh);
         pulse(vt[i].rdy, vt[i].s0, vt[i].s1, vt[i].s2, t);
         sb.push_back('{vt[i].out, vt[i].clp, 0, t + N + 3});
         drain();
      end

      voice_enable = 3'b111;
      shift        = 3'd0;
      pulse(3'b001, 1000, 0, 0, t);
      wait_to(t + 4);
      pulse(3'b010, 0, 1000, 0, t1);
      wait_to(t1 + 3);
      pulse(3'b100, 0, 0, 1000, t2);
      check("stagger_spacing", t2 - t, 9);
      sb.push_back('{3000, 0, 0, t2 + 5});
      drain();

      pulse(3'b001, 123, 0, 0, t);
      sb.push_back('{123, 0, 1, t + N + 3 + TO - 1});
      drain();

      // Dropping enables mid-COLLECT excludes voice 1's captured sample.
      pulse(3'b011, 7, 8, 0, t);
      wait_to(t + 2);
      @(negedge clk);
      voice_enable = 3'b001;
      sb.push_back('{7, 0, 0, t + 7});
      drain();
      voice_enable = 3'b111;

      // A frame arriving during ACCUM is carried into the following frame.
      pulse(3'b111, 10, 20, 30, t);
      sb.push_back('{60, 0, 0, t + 6});
      wait_to(t + 2);
      pulse(3'b111, 1, 2, 3, t2);
      sb.push_back('{6, 0, 0, t + 11});
      drain();

      voice_enable = 3'b000;
      p0 = pulses;
      pulse(3'b111, 5, 5, 5, t);
      repeat (20) @(negedge clk);
      check("all_disabled_no_pulse", pulses, p0);
      voice_enable = 3'b111;

      // Reset in the middle of ACCUM discards the frame.
      pulse(3'b111, 1, 2, 3, t);
      wait_to(t + 3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_sample_out", int'($signed(sample_out)), 0);
      check("midreset_ready", int'(new_sample_ready), 0);
      p0 = pulses;
      repeat (15) @(negedge clk);
      check("midreset_no_pulse", pulses, p0);
      pulse(3'b111, 1, 2, 3, t);
      sb.push_back('{6, 0, 0, t + N + 3});
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Parametrised N-voice sample mixer between the note_player instances and the echo stage.
- Replaces the ad-hoc combinational three-voice sum and AND of ready flags.
- Captures each voice's sample on its own new_sample_ready pulse and waits until every enabled voice has reported, with a timeout.
- Then accumulates serially, attenuates, saturates and emits one mixed sample with a single-cycle ready pulse.

Parameters:
NUM_VOICES, 3, number of voice inputs (1..8)
WIDTH, 16, sample width, two's complement
SHIFT_W, 3, width of the attenuation shift control
TIMEOUT, 64, cycles a partial frame may wait before forced output (must be >= 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
voice_samples  in  NUM_VOICES*WIDTH  packed samples; voice i at [i*WIDTH +: WIDTH]
voice_ready  in  NUM_VOICES  per-voice new_sample_ready pulse
voice_enable  in  NUM_VOICES  1 = voice participates; 0 = muted and not waited for
shift  in  SHIFT_W  arithmetic right-shift applied to the sum
sample_out  out  WIDTH  mixed, saturated sample; held until the next frame
new_sample_ready  out  1  one-cycle pulse when sample_out updates
clip  out  1  high with new_sample_ready when saturation occurred
timeout  out  1  high with new_sample_ready when the frame was forced by timeout

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: sample_out=0, new_sample_ready=0, clip=0, timeout=0, state=IDLE, collected=0, counters=0.
- Capture:
  - When voice_ready[i]=1 and voice_enable[i]=1 in any state, cap[i] <= sample i and collected[i] <= 1.
  - A repeat ready from voice i in the same frame overwrites cap[i].
  - Ready from a disabled voice is ignored.
- FSM states: IDLE, COLLECT, ACCUM, OUT.
- IDLE: go to COLLECT on the first cycle where collected is non-zero.
- COLLECT:
  - wait_cnt increments each cycle.
  - done = &(collected | ~voice_enable), using the live voice_enable.
  - If done, or wait_cnt == TIMEOUT-1: snapshot work[] <= cap[], mask <= collected & voice_enable, set timeout_flag = !done. Then clear collected and wait_cnt, and go to ACCUM.
  - A ready in the snapshot cycle belongs to the new frame. Its sample is included in work only if it arrived earlier.
- ACCUM:
  - idx runs 0..NUM_VOICES-1, one voice per cycle.
  - acc += mask[idx] ? sign-extended work[idx] : 0.
  - acc width is WIDTH+$clog2(NUM_VOICES)+1 and cannot overflow.
  - acc clears on entry. Go to OUT after the last idx.
- OUT:
  - scaled = acc >>> shift (arithmetic).
  - If scaled > 2^(WIDTH-1)-1, sample_out = max and clip=1. If scaled < -2^(WIDTH-1), sample_out = min and clip=1. Otherwise truncate and clip=0.
  - new_sample_ready=1 and timeout=timeout_flag for this cycle only.
  - Next state: COLLECT if collected != 0, else IDLE.
- Latency: new_sample_ready asserts NUM_VOICES+1 cycles after the COLLECT exit cycle.
- Captures arriving during ACCUM/OUT are kept for the next frame and never lost.
- All voices disabled: no frames start and outputs stay idle.
- voice_enable dropping mid-COLLECT:
  - The dropped voice is no longer awaited.
  - Its already captured sample is excluded, because mask is ANDed with voice_enable at the snapshot.
- Reset mid-operation clears all state. No pulse is emitted; a partial frame is discarded.
- Upstream frame rate is assumed slower than NUM_VOICES+2 cycles. Faster input merges frames (last-write-wins), which is not an error.

Decomposition:
- Shared package mixer_pkg: state enum (IDLE, COLLECT, ACCUM, OUT), function sat_trunc(value, width) returning the saturated result and clip bit, and the ACC_W constant expression.
- One natural sub-module: mixer_saturate, combinational shift+saturate, reusable by the echo stage.
- Capture registers, FSM and accumulator stay in voice_mixer.

Test Plan:
- Defaults, shift=0, all enabled; voices give 100, 200, -50 on the same cycle -> one pulse 4 cycles after COLLECT exit; sample_out=250, clip=0, timeout=0.
- Staggered readies at cycles 0, 5, 9 with samples 1000, 1000, 1000 -> single pulse after the third ready; sample_out=3000; no pulse earlier.
- Samples 30000, 30000, 30000 with shift=0 -> sample_out=32767, clip=1. With shift=2 -> sample_out=22500, clip=0. Samples -32768 ×3 with shift=0 -> -32768, clip=1.
- voice_enable=3'b011, voice 2 pulses with 5000, voices 0 and 1 give 7 and 8 -> sample_out=15; voice 2 ignored.
- TIMEOUT=64; only voice 0 reports 123 -> pulse at the 64th COLLECT cycle + latency, sample_out=123, timeout=1.
- Assert reset during ACCUM -> no pulse, sample_out=0. A following full frame of 1,2,3 -> sample_out=6. Also check that a ready arriving during ACCUM is carried into the next frame.
